// File: rtl/bus_region_pkg.sv
// ============================================================================
// bus_region_pkg: shared types, config byte offsets and reset memory map
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_region_pkg;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] limit;
    logic [7:0]  ws;
    logic        en;
  } region_cfg_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] c_ofs_base_lo  = 3'd0;
  localparam logic [2:0] c_ofs_base_hi  = 3'd1;
  localparam logic [2:0] c_ofs_limit_lo = 3'd2;
  localparam logic [2:0] c_ofs_limit_hi = 3'd3;
  localparam logic [2:0] c_ofs_ws       = 3'd4;
  localparam logic [2:0] c_ofs_ctrl     = 3'd5;

  function automatic region_cfg_t default_region(input int idx);
    region_cfg_t d;
    d = '0;
    case (idx)
      0: begin d.base = 16'h8000; d.limit = 16'hFFFF; d.ws = 8'd0; d.en = 1'b1; end
      1: begin d.base = 16'h0000; d.limit = 16'h7FEF; d.ws = 8'd0; d.en = 1'b1; end
      2: begin d.base = 16'h7FF0; d.limit = 16'h7FF3; d.ws = 8'd0; d.en = 1'b1; end
      3: begin d.base = 16'h7FF4; d.limit = 16'h7FF5; d.ws = 8'd2; d.en = 1'b1; end
      4: begin d.base = 16'h7FFF; d.limit = 16'h7FFF; d.ws = 8'd0; d.en = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_region_decoder_region_match.sv
// ============================================================================
// region_match: inclusive unsigned window comparator for one decode region
// Rev 1.0
// ============================================================================
`default_nettype none

module region_match #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           base,
  input  logic [15:0]           limit,
  input  logic                  en,
  output logic                  hit
);

  logic [15:0] w_addr;

  assign w_addr = 16'(addr);
  // limit < base can never satisfy both bounds, so it needs no special case
  assign hit    = en && (w_addr >= base) && (w_addr <= limit);

endmodule

`default_nettype wire

// File: rtl/bus_region_decoder.sv
// ============================================================================
// bus_region_decoder: programmable 6502 address decoder with wait-state RDY
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_region_decoder
  import bus_region_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_REGIONS = 8,
  parameter int WS_WIDTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             strobe,
  output logic [NUM_REGIONS-1:0]           cs,
  output logic                             rdy,
  output logic                             miss,
  input  logic                             miss_clr,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_REGIONS)+2:0]   cfg_addr,
  input  logic [7:0]                       cfg_wdata,
  output logic [7:0]                       cfg_rdata
);

  localparam int         c_cfg_aw  = $clog2(NUM_REGIONS) + 3;
  localparam logic [7:0] c_ws_mask = 8'((1 << WS_WIDTH) - 1);

  region_cfg_t             r_cfg [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]  w_hit;
  logic [NUM_REGIONS-1:0]  w_cs;
  logic                    w_any_hit;
  logic [WS_WIDTH-1:0]     w_win_ws;
  logic [c_cfg_aw-1:0]     w_cfg_region;
  logic [2:0]              w_cfg_ofs;

  state_t                  r_state, w_state_next;
  logic [WS_WIDTH-1:0]     r_cnt, w_cnt_next;
  logic                    r_rdy, w_rdy_next;
  logic                    r_miss, w_miss_next;

  assign w_cfg_region = cfg_addr >> 3;
  assign w_cfg_ofs    = cfg_addr[2:0];

  // Region index beyond NUM_REGIONS matches nothing, so such writes drop out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGIONS; r++) r_cfg[r] <= default_region(r);
    end else if (cfg_we) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (w_cfg_region == c_cfg_aw'(r)) begin
          case (w_cfg_ofs)
            c_ofs_base_lo:  r_cfg[r].base[7:0]   <= cfg_wdata;
            c_ofs_base_hi:  r_cfg[r].base[15:8]  <= cfg_wdata;
            c_ofs_limit_lo: r_cfg[r].limit[7:0]  <= cfg_wdata;
            c_ofs_limit_hi: r_cfg[r].limit[15:8] <= cfg_wdata;
            c_ofs_ws:       r_cfg[r].ws          <= cfg_wdata & c_ws_mask;
            c_ofs_ctrl:     r_cfg[r].en          <= cfg_wdata[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (w_cfg_region == c_cfg_aw'(r)) begin
        case (w_cfg_ofs)
          c_ofs_base_lo:  cfg_rdata = r_cfg[r].base[7:0];
          c_ofs_base_hi:  cfg_rdata = r_cfg[r].base[15:8];
          c_ofs_limit_lo: cfg_rdata = r_cfg[r].limit[7:0];
          c_ofs_limit_hi: cfg_rdata = r_cfg[r].limit[15:8];
          c_ofs_ws:       cfg_rdata = r_cfg[r].ws;
          c_ofs_ctrl:     cfg_rdata = {7'd0, r_cfg[r].en};
          default:        cfg_rdata = '0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    region_match #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_match (
      .addr  (addr),
      .base  (r_cfg[g].base),
      .limit (r_cfg[g].limit),
      .en    (r_cfg[g].en),
      .hit   (w_hit[g])
    );
  end

  // Lowest index wins; its wait-state count travels with the select
  always_comb begin
    w_cs      = '0;
    w_any_hit = 1'b0;
    w_win_ws  = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (w_hit[r] && !w_any_hit) begin
        w_cs[r]   = 1'b1;
        w_any_hit = 1'b1;
        w_win_ws  = r_cfg[r].ws[WS_WIDTH-1:0];
      end
    end
  end

  assign cs   = w_cs;
  assign rdy  = r_rdy;
  assign miss = r_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b1;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdy   <= w_rdy_next;
      r_miss  <= w_miss_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdy_next   = r_rdy;
    w_miss_next  = r_miss;
    case (r_state)
      ST_IDLE: begin
        if (strobe && w_any_hit && (w_win_ws != '0)) begin
          w_cnt_next   = w_win_ws;
          w_state_next = ST_WAIT;
          w_rdy_next   = 1'b0;
        end
        if (strobe && !w_any_hit) w_miss_next = 1'b1;
        else if (miss_clr)        w_miss_next = 1'b0;
      end
      ST_WAIT: begin
        if (r_cnt <= WS_WIDTH'(1)) begin
          w_cnt_next   = '0;
          w_rdy_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
        if (miss_clr) w_miss_next = 1'b0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rdy_next   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/bus_region_decoder.md
# bus_region_decoder

Parametrised, run-time programmable address decoder for the 6502 system bus. It replaces the fixed memory map with NUM_REGIONS windows, each holding a base, limit, enable and wait-state count, all writable from a byte-wide config port. It produces one-hot chip selects and a registered RDY wait-state generator so slow peripherals can stretch CPU cycles. It also flags accesses that hit no region. It sits between the CPU address bus and every peripheral chip select in the top level.

## Interface
- ADDR_WIDTH, 16, CPU address width.
- NUM_REGIONS, 8, number of decode windows; range 1..16.
- WS_WIDTH, 4, wait-state counter width; max stretch is 2^WS_WIDTH-1 cycles.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  CPU address; held stable from strobe until rdy is high.
- strobe  in  1  one-cycle pulse marking the start of a bus access.
- cs  out  NUM_REGIONS  one-hot region select, combinational from addr and the current config.
- rdy  out  1  registered ready to the CPU; low while wait states are pending.
- miss  out  1  sticky flag: a strobe occurred with no region hit.
- miss_clr  in  1  clears miss.
- cfg_we  in  1  config write enable.
- cfg_addr  in  $clog2(NUM_REGIONS)+3  config byte address.
- cfg_wdata  in  8  config write data.
- cfg_rdata  out  8  config read data, combinational.

## Operation
- Each region r occupies config bytes r*8+0..7:
  - +0 base[7:0], +1 base[15:8], +2 limit[7:0], +3 limit[15:8].
  - +4 ws[WS_WIDTH-1:0], upper bits read as 0.
  - +5 ctrl, bit0 = en, other bits read as 0.
  - +6 and +7 are reserved: they read 0 and writes are ignored.
- Hit condition: en && base <= addr <= limit, inclusive and unsigned. limit < base never hits.
- Priority: the lowest-index hitting region wins. cs has at most one bit set; cs = 0 if nothing hits.
- Reset defaults, regions 0..4; regions at index ≥ 5 reset to all-zero, which means disabled.
  - 0: 0x8000–0xFFFF, ws 0 (ROM).
  - 1: 0x0000–0x7FEF, ws 0 (RAM).
  - 2: 0x7FF0–0x7FF3, ws 0 (hex display).
  - 3: 0x7FF4–0x7FF5, ws 2 (UART).
  - 4: 0x7FFF–0x7FFF, ws 0 (IRQ status).
  - If NUM_REGIONS < 5, only the first NUM_REGIONS defaults apply.
- Wait-state FSM, states IDLE and WAIT, with a WS_WIDTH down-counter:
  - IDLE, strobe, winning region ws = N > 0: latch N into the counter, go to WAIT, rdy ← 0.
  - IDLE, strobe, ws = 0 or no hit: stay in IDLE, rdy stays 1.
  - WAIT: decrement each cycle. At count 1, rdy ← 1 and go to IDLE.
  - strobe in WAIT is ignored: no restart and no miss update.
- miss is set on a strobe in IDLE with no hit. Set has priority over a simultaneous miss_clr.
- Config writes during WAIT take effect on the next cycle. The in-flight count is unaffected.

## Timing
- Reset values: rdy = 1, miss = 0, FSM = IDLE, counter = 0, config = defaults. cs follows the defaults immediately after reset.
- Wait-state latency: strobe in cycle 0 with ws = N gives rdy = 0 in cycles 1..N and rdy = 1 from cycle N+1.
- A config write in cycle k is visible in cs and cfg_rdata from cycle k+1.
- strobe and cfg_we in the same cycle: decode and ws use the pre-write config.
- rst asserted during WAIT: rdy = 1 and IDLE after that edge, and config returns to defaults.
- Back-to-back strobes are legal in IDLE, one access per cycle.

## Structure
- Package bus_region_pkg holds:
  - the region_cfg_t struct {base, limit, ws, en};
  - config byte offset constants;
  - the default region table function, indexed by region.
- One sub-module, region_match: a single window comparator producing hit. It is instantiated NUM_REGIONS times, and the top level holds the priority encoder, FSM and config registers.

## Test plan
1. After reset, strobe at 0x7FF4 → cs = 0b00001000, rdy low in cycles 1–2, high in cycle 3; strobe at 0x9000 → cs[0] = 1 and rdy never drops.
2. Write region 5 to base 0x7FF8, limit 0x7FFB, ws 3, en 1 → strobe at 0x7FF9 gives cs[5] = 1 and rdy low for exactly 3 cycles; cfg_rdata at offset 0x2C reads 0x03.
3. Overlap: set region 6 to 0x0000–0xFFFF, en 1 → strobe at 0x1234 still selects region 1 (priority); disable region 1 → cs[6] = 1.
4. Clear en on region 4, strobe at 0x7FFF → cs = 0, miss = 1, rdy stays 1; miss_clr with no strobe → miss = 0; miss_clr together with an unmapped strobe → miss stays 1.
5. Strobe at 0x7FF4, assert rst in cycle 1 → rdy = 1 in cycle 2; repeating the access after reset still gives 2 wait states.
6. During WAIT, rewrite region 3 ws to 0 and issue a strobe → current wait still lasts 2 cycles and the mid-wait strobe is ignored; the next access has no wait.
